// File: rtl/fpu_mul_issue_if.sv
// Requester-side handshake bundle for the FP32 multiplier issue controller:
// two issue channels (operands in, ready out) and two result-return channels.
interface fpu_mul_issue_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;

    logic        resp0_valid;
    logic        resp0_ready;
    logic [31:0] resp0_result;
    logic        resp0_error;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp1_result;
    logic        resp1_error;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_result, resp0_error,
        input  resp1_valid, resp1_result, resp1_error
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_result, resp0_error,
        output resp1_valid, resp1_result, resp1_error
    );
endinterface

// File: rtl/fpu_mul_issue_ctrl.sv
// Issue/return controller for the STAGES-deep FP32 multiplier: round-robin
// grant between two requesters, per-stage valid/owner tracking, global stall.
module fpu_mul_issue_ctrl #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             nRESET,
    fpu_mul_issue_if.slave   req_if,
    output logic [31:0]      pipe_in_a,
    output logic [31:0]      pipe_in_b,
    output logic             pipe_en,
    input  logic [31:0]      pipe_out_result,
    input  logic             pipe_out_error,
    output logic [CNT_W-1:0] inflight,
    output logic             idle
);

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] t_q, t_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;

    logic grant_any_s;
    logic grant_id_s;
    logic final_v_s;
    logic final_t_s;
    logic owner_ready_s;
    logic stall_s;
    logic accept_s;
    logic retire_s;

    // Round-robin grant: a tie goes to the requester that did not win last.
    always_comb begin
        grant_any_s = 1'b0;
        grant_id_s  = 1'b0;
        case ({req_if.req1_valid, req_if.req0_valid})
            2'b01: begin
                grant_any_s = 1'b1;
                grant_id_s  = 1'b0;
            end
            2'b10: begin
                grant_any_s = 1'b1;
                grant_id_s  = 1'b1;
            end
            2'b11: begin
                grant_any_s = 1'b1;
                grant_id_s  = ~last_grant_q;
            end
            default: begin
                grant_any_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        endcase
    end

    // Stall when the final stage holds a result its owner cannot take yet.
    always_comb begin
        final_v_s = v_q[STAGES-1];
        final_t_s = t_q[STAGES-1];
        if (final_t_s) begin
            owner_ready_s = req_if.resp1_ready;
        end else begin
            owner_ready_s = req_if.resp0_ready;
        end
        stall_s  = final_v_s && !owner_ready_s;
        accept_s = grant_any_s && !stall_s && nRESET;
        retire_s = final_v_s && !stall_s;
    end

    // Requester-facing outputs and operand mux; requester 0 is the idle default.
    always_comb begin
        pipe_en           = ~stall_s;
        req_if.req0_ready = accept_s && !grant_id_s;
        req_if.req1_ready = accept_s && grant_id_s;
        if (grant_id_s) begin
            pipe_in_a = req_if.req1_a;
            pipe_in_b = req_if.req1_b;
        end else begin
            pipe_in_a = req_if.req0_a;
            pipe_in_b = req_if.req0_b;
        end
        req_if.resp0_valid  = final_v_s && !final_t_s;
        req_if.resp1_valid  = final_v_s && final_t_s;
        req_if.resp0_result = pipe_out_result;
        req_if.resp0_error  = pipe_out_error;
        req_if.resp1_result = pipe_out_result;
        req_if.resp1_error  = pipe_out_error;
        inflight            = inflight_q;
        idle                = !nRESET ||
                              ((inflight_q == {CNT_W{1'b0}}) &&
                               !req_if.req0_valid && !req_if.req1_valid);
    end

    // Next state: the whole valid/tag shift register moves only when enabled.
    always_comb begin
        v_d          = v_q;
        t_d          = t_q;
        last_grant_d = last_grant_q;
        if (!stall_s) begin
            v_d = {v_q[STAGES-2:0], accept_s};
            t_d = {t_q[STAGES-2:0], grant_id_s};
            if (accept_s) begin
                last_grant_d = grant_id_s;
            end else begin
                last_grant_d = last_grant_q;
            end
        end else begin
            v_d          = v_q;
            t_d          = t_q;
            last_grant_d = last_grant_q;
        end
        case ({accept_s, retire_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset discards every in-flight operation.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            v_q          <= {STAGES{1'b0}};
            t_q          <= {STAGES{1'b0}};
            last_grant_q <= 1'b1;
            inflight_q   <= {CNT_W{1'b0}};
        end else begin
            v_q          <= v_d;
            t_q          <= t_d;
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fpu_mul_issue_ctrl.sv
// Scoreboard bench: a per-cycle op-age model predicts grants, stalls and
// response timing; a simple FP32 multiply model plays the external datapath.
module tb_fpu_mul_issue_ctrl;
    localparam int STAGES = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             nRESET;
    logic [31:0]      pipe_in_a, pipe_in_b;
    logic             pipe_en;
    logic [31:0]      pipe_out_result;
    logic             pipe_out_error;
    logic [CNT_W-1:0] inflight;
    logic             idle;

    fpu_mul_issue_if bus ();

    fpu_mul_issue_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .nRESET(nRESET), .req_if(bus),
        .pipe_in_a(pipe_in_a), .pipe_in_b(pipe_in_b), .pipe_en(pipe_en),
        .pipe_out_result(pipe_out_result), .pipe_out_error(pipe_out_error),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Truncating FP32 multiply; inf*0 flags an error and returns a quiet NaN.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] m;
        logic [22:0] f;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && b[30:0] == 31'd0) || (eb == 255 && a[30:0] == 31'd0))
            return {1'b1, 32'h7FC00000};
        if (ea == 255 || eb == 255) return {1'b0, s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 0) return {1'b0, s, 31'd0};
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = ea + eb - 127;
        if (m[47]) begin
            f = m[46:24];
            e++;
        end else begin
            f = m[45:23];
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], f};
    endfunction

    // External datapath stand-in: STAGES result registers sharing pipe_en.
    logic [32:0] dr [STAGES];
    always @(posedge clk) begin
        if (pipe_en) begin
            dr[0] <= fmul(pipe_in_a, pipe_in_b);
            for (int i = 1; i < STAGES; i++) dr[i] <= dr[i-1];
        end
    end
    assign pipe_out_result = dr[STAGES-1][31:0];
    assign pipe_out_error  = dr[STAGES-1][32];

    typedef struct {
        bit          tag;
        int          acc;
        logic [32:0] exp;
    } op_t;

    op_t         mq[$];
    int          adv;
    bit          m_last;
    logic [31:0] last0_res;
    logic        last0_err;

    // Monitor: ops age one step per enabled edge; the oldest is presented at age STAGES-1.
    initial begin
        bit presented, htag, own_rdy, pe, v0, v1, gany, gid;
        forever begin
            @(negedge clk);
            if (!nRESET) begin
                check("rst_resp0_valid", bus.resp0_valid, 1'b0);
                check("rst_resp1_valid", bus.resp1_valid, 1'b0);
                check("rst_req0_ready", bus.req0_ready, 1'b0);
                check("rst_req1_ready", bus.req1_ready, 1'b0);
                check("rst_pipe_en", pipe_en, 1'b1);
                check("rst_inflight", inflight, 0);
                check("rst_idle", idle, 1'b1);
                mq.delete();
                adv    = 0;
                m_last = 1'b1;
            end else begin
                presented = (mq.size() > 0) && (adv - mq[0].acc == STAGES - 1);
                htag      = presented ? mq[0].tag : 1'b0;
                own_rdy   = htag ? bus.resp1_ready : bus.resp0_ready;
                pe        = !(presented && !own_rdy);
                v0        = bus.req0_valid;
                v1        = bus.req1_valid;
                gany      = v0 || v1;
                gid       = (v0 && v1) ? !m_last : v1;
                check("resp0_valid", bus.resp0_valid, presented && !htag);
                check("resp1_valid", bus.resp1_valid, presented && htag);
                check("pipe_en", pipe_en, pe);
                check("req0_ready", bus.req0_ready, pe && gany && !gid);
                check("req1_ready", bus.req1_ready, pe && gany && gid);
                check("inflight", inflight, mq.size());
                check("idle", idle, (mq.size() == 0) && !v0 && !v1);
                if (presented && pe) begin
                    if (htag) begin
                        check("resp1_data", {bus.resp1_error, bus.resp1_result}, mq[0].exp);
                    end else begin
                        check("resp0_data", {bus.resp0_error, bus.resp0_result}, mq[0].exp);
                        last0_res = bus.resp0_result;
                        last0_err = bus.resp0_error;
                    end
                    void'(mq.pop_front());
                end
                if (gany && pe) begin
                    mq.push_back('{tag: gid, acc: adv + 1,
                                   exp: gid ? fmul(bus.req1_a, bus.req1_b)
                                            : fmul(bus.req0_a, bus.req0_b)});
                    m_last = gid;
                end
                if (pe) adv++;
            end
        end
    end

    // Per-cycle driver: a pending request is held until accepted (percent knobs).
    task automatic run(input int n, input int p0, input int p1, input int r0, input int r1);
        bit a0, a1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk);
            #1;
            if (!bus.req0_valid || a0) begin
                bus.req0_valid = ($urandom_range(99) < p0);
                bus.req0_a     = $urandom;
                bus.req0_b     = $urandom;
            end
            if (!bus.req1_valid || a1) begin
                bus.req1_valid = ($urandom_range(99) < p1);
                bus.req1_a     = $urandom;
                bus.req1_b     = $urandom;
            end
            bus.resp0_ready = ($urandom_range(99) < r0);
            bus.resp1_ready = ($urandom_range(99) < r1);
        end
    endtask

    initial begin
        nRESET = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        last0_res = 32'd0; last0_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 nRESET = 1'b1;

        // Single op 1.5 * 2.0
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000;
        run(8, 0, 0, 100, 100);
        check("single_result", last0_res, 32'h40400000);

        // Tie, then req1 fills the pipe under backpressure
        run(6, 100, 100, 100, 100);
        run(10, 0, 0, 100, 100);
        run(5, 0, 100, 100, 0);
        run(3, 0, 0, 100, 0);
        check("bp_pipe_en", pipe_en, 1'b0);
        check("bp_inflight", inflight, 4);
        check("bp_req1_ready", bus.req1_ready, 1'b0);
        check("bp_result_stable", {bus.resp1_error, bus.resp1_result}, mq[0].exp);
        run(12, 0, 0, 100, 100);

        // Stream from req0
        run(12, 100, 0, 100, 100);
        run(10, 0, 0, 100, 100);

        // Error passthrough: 0 * inf
        bus.req0_valid = 1'b1; bus.req0_a = 32'h00000000; bus.req0_b = 32'h7F800000;
        run(8, 0, 0, 100, 100);
        check("err_flag", last0_err, 1'b1);
        check("err_result", last0_res, 32'h7FC00000);

        // Reset with 3 ops in flight
        run(4, 100, 0, 100, 100);
        check("pre_rst_inflight", inflight, 3);
        nRESET = 1'b0;
        #1;
        check("mid_rst_inflight", inflight, 0);
        check("mid_rst_idle", idle, 1'b1);
        check("mid_rst_resp0_valid", bus.resp0_valid, 1'b0);
        bus.req0_valid = 1'b1; bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_valid = 1'b1; bus.req1_a = $urandom; bus.req1_b = $urandom;
        repeat (2) @(posedge clk);
        #1 nRESET = 1'b1;
        #1;
        check("post_rst_tie_req0", bus.req0_ready, 1'b1);
        check("post_rst_tie_req1", bus.req1_ready, 1'b0);
        run(6, 100, 100, 100, 100);

        // Randomized traffic with random backpressure
        run(3000, 60, 60, 70, 70);

        run(20, 0, 0, 100, 100);
        check("drain_empty", mq.size(), 0);
        check("drain_idle", idle, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_mul_issue_ctrl.md
Name: fpu_mul_issue_ctrl

Overview:
- Issue/return controller for the 4-stage FP32 multiplier pipeline. The stage register banks carry sign, exponents, fractions, special-case bypass, error and partial products.
- Round-robin arbitration shares the one pipeline between two requesters.
- Tracks a valid bit and an owner tag per stage, generates the global stage-enable (stall), and routes each result back to its owner.
- Sits between the requester ports and the stage 1..4 register banks; the datapath itself is outside this block.

Parameters:
- STAGES, 4, register stages from issue to result; legal range 2..8
- CNT_W, 4, width of the in-flight counter; must satisfy 2^CNT_W > STAGES

Ports:
- clk  in  1  single clock; all flops on rising edge
- nRESET  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_a  in  32  requester 0 operand A (IEEE-754 single)
- req0_b  in  32  requester 0 operand B
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready: same roles for requester 1
- pipe_in_a  out  32  operand A to stage-1 input, muxed from the granted requester
- pipe_in_b  out  32  operand B to stage-1 input
- pipe_en  out  1  global enable for all stage register banks; 0 = freeze
- pipe_out_result  in  32  final-stage result from the datapath
- pipe_out_error  in  1  final-stage error flag from the datapath
- resp0_valid  out  1  result available for requester 0
- resp0_ready  in  1  requester 0 takes the result
- resp0_result  out  32  equals pipe_out_result
- resp0_error  out  1  equals pipe_out_error
- resp1_valid, resp1_ready, resp1_result, resp1_error: same roles for requester 1
- inflight  out  CNT_W  number of valid stages
- idle  out  1  1 when inflight==0 and no request is pending

Behaviour:
- State:
  - v[0..STAGES-1]: stage valid bits
  - t[0..STAGES-1]: owner tags
  - last_grant: 1-bit round-robin pointer
  - inflight: counter
- Reset (nRESET low, asynchronous):
  - v=0, t=0, last_grant=1 (requester 0 wins the first tie), inflight=0.
  - Outputs: resp*_valid=0, req*_ready=0, pipe_en=1, idle=1.
  - Reset asserted mid-operation discards all in-flight operations. No response is issued for them.
- Stall: stall = v[STAGES-1] && !resp_ready[t[STAGES-1]]. pipe_en = !stall.
- Response:
  - respN_valid = v[STAGES-1] && t[STAGES-1]==N.
  - A result is consumed when valid and ready are both high on the same edge.
  - respN_result and respN_error are combinational passthroughs. Consumers ignore them while respN_valid=0.
- Grant (combinational):
  - Only req0_valid high -> grant 0.
  - Only req1_valid high -> grant 1.
  - Both high -> grant !last_grant.
  - Neither high -> no grant; pipe_in muxes select requester 0.
- Accept: reqN_ready = pipe_en && grant==N. A request is accepted when it is valid and ready on the same edge; last_grant<=N on accept. Requesters hold valid and operands stable until accepted.
- Advance (only when pipe_en=1):
  - v[0]<=accept, t[0]<=granted id.
  - v[i]<=v[i-1], t[i]<=t[i-1] for i>=1.
  - When pipe_en=0, v, t and last_grant hold.
- Latency:
  - An operation accepted at edge k has respN_valid high during the cycle after edge k+STAGES-1, i.e. STAGES cycles after the accept cycle, when there is no stall.
  - Throughput is 1 operation per cycle with no bubbles.
- Stall behaviour:
  - A stall freezes the whole pipeline, including stage 1; no request is accepted.
  - Bubbles are not collapsed.
  - The non-owning requester's resp_ready has no effect.
- inflight update (each edge):
  - +1 on accept.
  - -1 when the final stage is valid and pipe_en=1 (that result is consumed).
  - Both -> unchanged.
  - Never exceeds STAGES. Equals popcount(v) at all times.
- Simultaneous events: with a valid final stage and resp_ready high, the pipeline shifts, the result is consumed and a new request is accepted on the same edge.
- idle = (inflight==0) && !req0_valid && !req1_valid.

Test Plan:
- Single op: req0 issues a=0x3FC00000, b=0x40000000 (1.5*2.0) with resp0_ready=1 -> resp0_valid is high exactly 4 cycles after accept; resp0_result=0x40400000; inflight goes 1,1,1,1,0.
- Tie: req0 and req1 both valid for 4 cycles with all resp_ready=1 -> grants alternate 0,1,0,1; responses return in order 0,1,0,1 with matching tags; resp1_valid is never high for a requester-0 op.
- Backpressure: pipeline full of 4 ops from req1, resp1_ready=0 for 3 cycles -> pipe_en=0, req*_ready=0, inflight holds at 4, result stable. On release, 4 responses follow on 4 consecutive cycles.
- Stream: req0 continuously valid with 8 ops -> one accept per cycle, no bubbles, inflight saturates at 4 and never reaches 5.
- Error passthrough: datapath model drives pipe_out_error=1 for b=0x7F800000 (inf) * a=0x00000000 -> resp0_error=1 together with resp0_valid.
- Reset mid-flight: nRESET pulsed low with 3 ops in flight -> resp*_valid drops immediately, inflight=0, idle=1; the next tie grants requester 0.
